// File: rtl/dmem_line_responder.sv
// Line-granular backing store for the D-cache refill/write-back port: one 256-bit
// request at a time, fixed LATENCY to a single-cycle ack. Optional checker: DMEM_PROTOCOL_CHECK_EN.
module dmem_line_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               complete;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [255:0]       wdata_q;
  logic               ack_q;
  logic [255:0]       data_q;
  logic [255:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]   idx_in;
  logic               unused_addr;

  // Offset bits and the aliased upper bits never select anything.
  assign idx_in      = addr_i[IDX_W+4:5];
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // Counter is loaded with LATENCY-1 so that the edge seeing zero is E(LATENCY).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= complete;
      if (accept) begin
        wr_q  <= write_i;
        idx_q <= idx_in;
      end
      if (complete && !wr_q) begin
        data_q <= mem_q[idx_q];
      end
    end
  end

  // NOTE: the line array and its write-data staging register are deliberately not reset;
  // a reset would turn the array into flops and contents are undefined until written anyway.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wdata_q <= data_i;
    end
    if (complete && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic err_q;

  // Initiator must hold req, direction and line index stable until ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (state_q == WAIT &&
                 (!req_i || (write_i != wr_q) || (idx_in != idx_q))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: table of line transactions plus
// hand-written reset, back-to-back and protocol-violation sequences.
module tb_dmem_line_responder;

  localparam int unsigned LAT = 10;

`ifdef DMEM_PROTOCOL_CHECK_EN
  localparam logic PROT_ERR = 1'b1;
`else
  localparam logic PROT_ERR = 1'b0;
`endif

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_P  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_X  = {8{32'h0F1E_2D3C}};
  localparam logic [255:0] PAT_R  = {8{32'h5555_AAAA}};
  localparam logic [255:0] PAT_Q  = {8{32'h7777_1111}};

  logic         clk_i;
  logic         rst_i;
  logic         req_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         err_o;

  int checks;
  int errors;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_data;  // data_o in the ack cycle (held value for writes)
  } vec_t;

  vec_t vecs [7];

  dmem_line_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .write_i (write_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .ack_o   (ack_o),
    .data_o  (data_o),
    .err_o   (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, count edges to ack, check data and the single-cycle pulse.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [255:0] exp_data);
    int lat;
    lat     = -1;
    req_i   = 1'b1;
    write_i = wr;
    addr_i  = addr;
    data_i  = wdata;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) lat = k;
    end
    check({tag, " latency"}, 256'(lat), 256'(LAT));
    check({tag, " data_o"}, data_o, exp_data);
    req_i   = 1'b0;
    write_i = 1'b0;
    addr_i  = '0;
    data_i  = '0;
    @(posedge clk_i); #1;
    check({tag, " ack width"}, 256'(ack_o), 256'(0));
    check({tag, " err_o"}, 256'(err_o), 256'(0));
  endtask

  initial begin
    int acks;
    int ack_at [2];
    int lat;
    checks  = 0;
    errors  = 0;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    write_i = 1'b0;
    addr_i  = '0;
    data_i  = '0;

    vecs[0] = '{1'b1, 32'h0000_0040, PAT_A5, 256'(0)};
    vecs[1] = '{1'b0, 32'h0000_0040, 256'(0), PAT_A5};
    vecs[2] = '{1'b1, 32'h0000_0000, PAT_P,  PAT_A5};
    vecs[3] = '{1'b0, 32'h0000_401F, 256'(0), PAT_P};
    vecs[4] = '{1'b1, 32'h0000_0020, PAT_X,  PAT_P};
    vecs[5] = '{1'b1, 32'h0000_0080, PAT_R,  PAT_P};
    vecs[6] = '{1'b0, 32'h0000_0020, 256'(0), PAT_X};

    // Reset release away from the clock edge, then idle with no requests.
    #12 rst_i = 1'b0;
    #1;
    check("reset ack_o", 256'(ack_o), 256'(0));
    check("reset data_o", data_o, 256'(0));
    check("reset err_o", 256'(err_o), 256'(0));
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) acks++;
    end
    check("idle no ack", 256'(acks), 256'(0));

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data);
    end

    // Back-to-back reads with req_i held high: acks at edges 10 and 22 after first acceptance.
    acks      = 0;
    ack_at[0] = -1;
    ack_at[1] = -1;
    req_i     = 1'b1;
    write_i   = 1'b0;
    addr_i    = 32'h0000_0040;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) begin
        if (acks < 2) ack_at[acks] = k;
        acks++;
        if (acks == 1) begin
          check("b2b first data", data_o, PAT_A5);
          addr_i = 32'h0000_0020;
        end else begin
          check("b2b second data", data_o, PAT_X);
          req_i = 1'b0;
        end
      end
    end
    req_i  = 1'b0;
    addr_i = '0;
    check("b2b ack count", 256'(acks), 256'(2));
    check("b2b first ack edge", 256'(ack_at[0]), 256'(LAT));
    check("b2b second ack edge", 256'(ack_at[1]), 256'(2 * LAT + 2));

    // Reset in WAIT cycle 5 abandons a write of Q over R at line 0x80.
    acks    = 0;
    req_i   = 1'b1;
    write_i = 1'b1;
    addr_i  = 32'h0000_0080;
    data_i  = PAT_Q;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) acks++;
    end
    #3 rst_i = 1'b1;
    #1;
    check("midwait no early ack", 256'(acks), 256'(0));
    check("midwait async data_o", data_o, 256'(0));
    check("midwait async ack_o", 256'(ack_o), 256'(0));
    check("midwait async err_o", 256'(err_o), 256'(0));
    req_i   = 1'b0;
    write_i = 1'b0;
    data_i  = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_txn("midwait readback", 1'b0, 32'h0000_0080, 256'(0), PAT_R);

    // Drop req_i in WAIT cycle 3; ack must still arrive on schedule.
    lat     = -1;
    req_i   = 1'b1;
    write_i = 1'b0;
    addr_i  = 32'h0000_0040;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk_i); #1;
      if (k == 3) begin
        check("proto err before drop", 256'(err_o), 256'(0));
        req_i = 1'b0;
      end
      if (k == 4) check("proto err after drop", 256'(err_o), 256'(PROT_ERR));
      if (ack_o === 1'b1) lat = k;
    end
    check("proto ack latency", 256'(lat), 256'(LAT));
    check("proto ack data", data_o, PAT_A5);
    check("proto err at ack", 256'(err_o), 256'(PROT_ERR));
    @(posedge clk_i); #1;
    check("proto ack width", 256'(ack_o), 256'(0));
    check("proto err sticky", 256'(err_o), 256'(PROT_ERR));
    #3 rst_i = 1'b1;
    #1;
    check("proto err cleared by reset", 256'(err_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
